programmable_clock_divider: RTL

PROGRAMMABLE_CLOCK_DIVIDER -- requirements
Module: programmable_clock_divider

---
 rtl/programmable_clock_divider.sv | 130 +++++++++++++
 1 files changed

// File: rtl/programmable_clock_divider.sv
`default_nettype none
// ============================================================================
// Module   : programmable_clock_divider
// Purpose  : N independent clock dividers with shadowed period/high-time
//            configuration, per-channel enable and a global phase restart.
// Revision : 1.0 - initial release
// ============================================================================
module programmable_clock_divider #(
  parameter int Channels      = 4,
  parameter int ChannelBits   = 2,
  parameter int Width         = 8,
  parameter int DefaultPeriod = 55,
  parameter int DefaultHigh   = 28
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [Channels-1:0]    en,
  input  logic                   sync,
  input  logic                   cfg_we,
  input  logic [ChannelBits-1:0] cfg_ch,
  input  logic [Width-1:0]       cfg_period,
  input  logic [Width-1:0]       cfg_high,
  output logic [Channels-1:0]    dclk,
  output logic [Channels-1:0]    tick,
  output logic [Channels-1:0]    running
);

  localparam logic [Width-1:0] c_def_period = Width'(DefaultPeriod);
  localparam logic [Width-1:0] c_def_high   = Width'(DefaultHigh);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  generate
    for (genvar gi = 0; gi < Channels; gi++) begin : g_ch
      state_t           r_state;
      logic [Width-1:0] r_shadow_period;
      logic [Width-1:0] r_shadow_high;
      logic [Width-1:0] r_active_period;
      logic [Width-1:0] r_active_high;
      logic [Width-1:0] r_count;
      logic             r_dclk;
      logic             r_tick;
      logic             r_running;
      logic             w_cfg_hit;
      logic             w_wrap;
      logic [Width-1:0] w_count_inc;

      // Out-of-range channel indices never match any generated channel.
      assign w_cfg_hit   = cfg_we && (32'(cfg_ch) == gi);
      assign w_wrap      = sync || (r_count == r_active_period);
      assign w_count_inc = r_count + Width'(1);

      always_ff @(posedge clk) begin
        if (rst) begin
          r_shadow_period <= c_def_period;
          r_shadow_high   <= c_def_high;
          r_active_period <= c_def_period;
          r_active_high   <= c_def_high;
          r_count         <= '0;
          r_state         <= S_IDLE;
          r_dclk          <= 1'b0;
          r_tick          <= 1'b0;
          r_running       <= 1'b0;
        end else begin
          if (w_cfg_hit) begin
            r_shadow_period <= cfg_period;
            r_shadow_high   <= cfg_high;
          end

          // Loads below read the shadow value from before this edge, so a
          // coincident write is deferred to the next period start.
          case (r_state)
            S_IDLE: begin
              r_count <= '0;
              if (en[gi]) begin
                r_state         <= S_RUN;
                r_running       <= 1'b1;
                r_active_period <= r_shadow_period;
                r_active_high   <= r_shadow_high;
                r_dclk          <= (r_shadow_high != '0);
                r_tick          <= 1'b1;
              end else begin
                r_running <= 1'b0;
                r_dclk    <= 1'b0;
                r_tick    <= 1'b0;
              end
            end

            S_RUN: begin
              if (!en[gi]) begin
                r_state   <= S_IDLE;
                r_running <= 1'b0;
                r_count   <= '0;
                r_dclk    <= 1'b0;
                r_tick    <= 1'b0;
              end else if (w_wrap) begin
                r_count         <= '0;
                r_active_period <= r_shadow_period;
                r_active_high   <= r_shadow_high;
                r_dclk          <= (r_shadow_high != '0);
                r_tick          <= 1'b1;
              end else begin
                r_count <= w_count_inc;
                r_dclk  <= (w_count_inc < r_active_high);
                r_tick  <= 1'b0;
              end
            end

            default: begin
              r_state   <= S_IDLE;
              r_running <= 1'b0;
              r_count   <= '0;
              r_dclk    <= 1'b0;
              r_tick    <= 1'b0;
            end
          endcase
        end
      end

      assign dclk[gi]    = r_dclk;
      assign tick[gi]    = r_tick;
      assign running[gi] = r_running;
    end
  endgenerate

endmodule
`default_nettype wire
